pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the MIPS III pipeline. It is the generalised successor of the hand-written stage latches. The payload is split into control bits, which are zeroed whenever the stage holds a bubble, and datapath bits, which hold their value on a bubble. Stall is replaced by a valid/ready handshake, with an optional 2-entry skid buffer so back-pressure is registered and not combinational. It adds synchronous flush and a saturating starvation counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 132 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// bubble-masked control field, synchronous flush and a saturating starvation counter.
module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // a source holding valid must keep its payload stable until that edge.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic              accept;
    logic              retire;

    assign out_valid  = (state_q != ST_EMPTY);
    assign out_ctrl   = main_ctrl_q;
    assign out_data   = main_data_q;
    assign bubble_cnt = bubble_cnt_q;
    assign dbg_state  = state_q;

    // With the skid buffer, in_ready comes straight from a flop; without it, it is combinational.
    assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~out_valid);
    assign accept   = in_valid & in_ready;
    assign retire   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        // Only reachable with the skid buffer: without it, accept in ONE implies retire.
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (retire) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                ST_TWO: begin
                    if (retire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                end
            endcase
        end
    end

    assign in_ready_d = (state_d != ST_TWO);

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (out_ready && !out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= ST_EMPTY;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid instance share one stimulus
// stream; each is checked against a queue-based occupancy model.
module tb_pipe_stage_reg;
  localparam int CW = 16;
  localparam int DW = 32;
  localparam int EW = CW + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready_s = 1'b0;
  logic          out_ready_n = 1'b0;

  logic          in_ready_s, out_valid_s, in_ready_n, out_valid_n;
  logic [CW-1:0] out_ctrl_s, out_ctrl_n;
  logic [DW-1:0] out_data_s, out_data_n;
  logic [3:0]    bubble_cnt_s;
  logic [15:0]   bubble_cnt_n;
  logic [1:0]    dbg_state_s, dbg_state_n;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_skid (
    .CLK(clk), .RST_N(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_ctrl(out_ctrl_s), .out_data(out_data_s),
    .bubble_cnt(bubble_cnt_s), .dbg_state(dbg_state_s)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_noskid (
    .CLK(clk), .RST_N(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_n), .out_ready(out_ready_n), .out_ctrl(out_ctrl_n), .out_data(out_data_n),
    .bubble_cnt(bubble_cnt_n), .dbg_state(dbg_state_n)
  );

  // reference model: held entries in acceptance order, plus counters
  logic [EW-1:0] exp_q_s[$];
  logic [EW-1:0] exp_q_n[$];
  int            cnt_m_s = 0;
  int            cnt_m_n = 0;
  logic [DW-1:0] last_d_s = '0;
  logic [DW-1:0] last_d_n = '0;
  logic          rdy_m_s = 1'b1;
  logic          rdy_m_n = 1'b1;
  bit            mon_en = 1'b0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: compares every cycle, pops on each observed retire
  always @(negedge clk) begin : monitor
    int            occ;
    logic [EW-1:0] fr;
    if (mon_en && rst_n) begin
      // skid lane
      occ = exp_q_s.size();
      fr = (occ != 0) ? exp_q_s[0] : '0;
      rdy_m_s = (occ < 2);
      if (occ != 0) last_d_s = fr[DW-1:0];
      chk("s_in_ready", in_ready_s, rdy_m_s);
      chk("s_out_valid", out_valid_s, occ != 0);
      chk("s_out_ctrl", out_ctrl_s, fr[EW-1:DW]);
      chk("s_out_data", out_data_s, last_d_s);
      chk("s_bubble_cnt", bubble_cnt_s, cnt_m_s);
      if (out_valid_s && out_ready_s) begin
        if (exp_q_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_retire: got unexpected entry %0h at %0t", {out_ctrl_s, out_data_s}, $time);
        end else begin
          fr = exp_q_s.pop_front();
          chk("s_retire", {out_ctrl_s, out_data_s}, fr);
        end
      end
      if (out_ready_s && occ == 0 && cnt_m_s < 15) cnt_m_s++;

      // no-skid lane
      occ = exp_q_n.size();
      fr = (occ != 0) ? exp_q_n[0] : '0;
      rdy_m_n = out_ready_n || (occ == 0);
      if (occ != 0) last_d_n = fr[DW-1:0];
      chk("n_in_ready", in_ready_n, rdy_m_n);
      chk("n_out_valid", out_valid_n, occ != 0);
      chk("n_out_ctrl", out_ctrl_n, fr[EW-1:DW]);
      chk("n_out_data", out_data_n, last_d_n);
      chk("n_bubble_cnt", bubble_cnt_n, cnt_m_n);
      if (out_valid_n && out_ready_n) begin
        if (exp_q_n.size() == 0) begin
          checks++; errors++;
          $display("FAIL n_retire: got unexpected entry %0h at %0t", {out_ctrl_n, out_data_n}, $time);
        end else begin
          fr = exp_q_n.pop_front();
          chk("n_retire", {out_ctrl_n, out_data_n}, fr);
        end
      end
      if (out_ready_n && occ == 0 && cnt_m_n < 65535) cnt_m_n++;
    end
  end

  // driver: apply one cycle of inputs, then record what that edge did to the model
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ors, input logic orn, input logic fl, input logic rn);
    rst_n = rn; flush = fl; in_valid = v; in_ctrl = c; in_data = d;
    out_ready_s = ors; out_ready_n = orn;
    @(posedge clk);
    #1;
    if (!rn) begin
      exp_q_s.delete(); exp_q_n.delete();
      cnt_m_s = 0; cnt_m_n = 0;
      last_d_s = '0; last_d_n = '0;
      mon_en = 1'b1;
    end else if (fl) begin
      exp_q_s.delete(); exp_q_n.delete();
    end else begin
      if (v && rdy_m_s) exp_q_s.push_back({c, d});
      if (v && rdy_m_n) exp_q_n.push_back({c, d});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // reset then stream
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, CW'(i), DW'(100 + 3 * i), 1'b1, 1'b1, 1'b0, 1'b1);
    chk("stream_bubble_s", bubble_cnt_s, 1);
    chk("stream_bubble_n", bubble_cnt_n, 1);
    idle(2);

    // back-pressure into the skid buffer
    step(1'b1, 16'h10, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h11, 32'h1100, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_in_ready_s", in_ready_s, 0);
    chk("bp_head_s", out_ctrl_s, 16'h10);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h12, 32'h1200, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_hold_s", out_ctrl_s, 16'h10);
    step(1'b1, 16'h12, 32'h1200, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("bp_drain1_s", out_ctrl_s, 16'h11);
    idle(4);

    // flush while both entries are held
    step(1'b1, 16'h20, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h21, 32'h2100, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h22, 32'h2200, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_valid_s", out_valid_s, 0);
    chk("flush_ctrl_s", out_ctrl_s, 0);
    chk("flush_data_s", out_data_s, 32'h2000);
    chk("flush_ready_s", in_ready_s, 1);
    idle(2);

    // bubble masking keeps data, zeroes control
    step(1'b1, 16'hFFFF, 32'hABC, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    chk("mask_ctrl_s", out_ctrl_s, 0);
    chk("mask_data_s", out_data_s, 32'hABC);
    chk("mask_data_n", out_data_n, 32'hABC);

    // saturation of the 4-bit counter
    idle(20);
    chk("sat_s", bubble_cnt_s, 15);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("sat_flush_s", bubble_cnt_s, 15);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_reset_s", bubble_cnt_s, 0);
    chk("sat_reset_n", bubble_cnt_n, 0);

    // no-skid lane with toggling out_ready and continuous input
    for (int i = 0; i < 12; i++)
      step(1'b1, CW'(16'h40 + i), DW'(32'h4000 + i), 1'b1, (i % 3) != 1, 1'b0, 1'b1);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, CW'($urandom), DW'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 299) != 0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
